// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display scanner.
//   DEF_SEG_W / DEF_NUM_DIGITS : default geometry of the attached display
//   scan_state_t               : scanner FSM states
//   SEG_BLANK                  : segment pattern with every segment off
package seg_display_pkg;

  localparam int unsigned DEF_SEG_W      = 7;
  localparam int unsigned DEF_NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [DEF_SEG_W-1:0] SEG_BLANK = '0;

endpackage

// File: rtl/seg_slot_counter.sv
// Slot and digit counters for the display scanner.
// Ports:
//   sys_clk, rst_b : clock, asynchronous active-high reset
//   clear          : hold both counters at zero (scanner idle)
//   slot_cnt       : cycle within the current digit slot, 0..CLK_DIV-1
//   digit_idx      : digit being scanned, 0..NUM_DIGITS-1
//   drive_start    : slot_cnt is on the last blank cycle
//   slot_end       : slot_cnt is on the last cycle of the slot
//   frame_end      : last cycle of the last digit's slot
//   frame_last     : one cycle before frame_end (lets frame_done be registered)
module seg_slot_counter #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 10,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned DIG_W        = 3
) (
  input  logic             sys_clk,
  input  logic             rst_b,
  input  logic             clear,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [DIG_W-1:0] digit_idx,
  output logic             drive_start,
  output logic             slot_end,
  output logic             frame_end,
  output logic             frame_last
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_PREV = CNT_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_d;
  logic [DIG_W-1:0] digit_d;

  assign slot_end    = (slot_cnt == SLOT_LAST);
  assign drive_start = (slot_cnt == BLANK_END);
  assign frame_end   = slot_end && (digit_idx == DIG_LAST);
  assign frame_last  = (slot_cnt == SLOT_PREV) && (digit_idx == DIG_LAST);

  always_comb begin
    slot_d  = slot_cnt;
    digit_d = digit_idx;
    if (clear) begin
      slot_d  = '0;
      digit_d = '0;
    end else if (slot_end) begin
      slot_d  = '0;
      digit_d = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_d = slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst_b) begin
    if (rst_b) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt  <= slot_d;
      digit_idx <= digit_d;
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexes NUM_DIGITS segment codes onto one shared segment bus with
// one-hot digit enables. Each digit slot is CLK_DIV cycles: BLANK_CYCLES of
// dead-time (everything off, against ghosting) then the digit is driven. The
// input codes are snapshotted once per frame so a frame never tears.
// Optional build macro DIM_PWM_EN adds a 4-bit brightness input that PWMs
// the segments (not the digit enable) during the drive phase.
// Ports:
//   sys_clk       : system clock
//   rst_b         : asynchronous reset, active-high
//   digit_segs_in : segment codes, digit 0 at index 0
//   disp_enable   : scan enable; low returns to idle with outputs off
//   brightness    : (DIM_PWM_EN only) 0..15, 15 = full on
//   seg_out       : segments of the active digit, active-high, registered
//   an_out        : one-hot digit enable, active-high, registered
//   frame_done    : one-cycle pulse on the last cycle of each frame
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned SEG_W        = DEF_SEG_W,
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 10
) (
  input  logic                             sys_clk,
  input  logic                             rst_b,
  input  logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_segs_in,
  input  logic                             disp_enable,
`ifdef DIM_PWM_EN
  input  logic [3:0]                       brightness,
`endif
  output logic [SEG_W-1:0]                 seg_out,
  output logic [NUM_DIGITS-1:0]            an_out,
  output logic                             frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (CLK_DIV <= BLANK_CYCLES) begin : g_bad_clk_div
    $error("seg_display_scan: CLK_DIV must be greater than BLANK_CYCLES");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_display_scan: BLANK_CYCLES must be at least 1");
  end

  scan_state_t                      state_q, state_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_q, snap_d;
  logic [SEG_W-1:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]            an_q, an_d;
  logic                             fd_q, fd_d;

  logic             cnt_clear;
  logic [CNT_W-1:0] slot_cnt;
  logic [DIG_W-1:0] digit_idx;
  logic             drive_start, slot_end, frame_end, frame_last;

`ifdef DIM_PWM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] off_next;
`endif

  seg_slot_counter #(
    .NUM_DIGITS  (NUM_DIGITS),
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W),
    .DIG_W       (DIG_W)
  ) u_counter (
    .sys_clk    (sys_clk),
    .rst_b      (rst_b),
    .clear      (cnt_clear),
    .slot_cnt   (slot_cnt),
    .digit_idx  (digit_idx),
    .drive_start(drive_start),
    .slot_end   (slot_end),
    .frame_end  (frame_end),
    .frame_last (frame_last)
  );

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    seg_d     = seg_q;
    an_d      = an_q;
    fd_d      = 1'b0;
    cnt_clear = 1'b1;
`ifdef DIM_PWM_EN
    bright_d  = bright_q;
    // Drive offset of the cycle the registered output is about to show.
    off_next  = 4'(32'(slot_cnt) + 32'd1 - 32'(BLANK_CYCLES));
`endif
    case (state_q)
      IDLE: begin
        seg_d = SEG_W'(SEG_BLANK);
        an_d  = '0;
        if (disp_enable) begin
          state_d  = BLANK;
          snap_d   = digit_segs_in;
`ifdef DIM_PWM_EN
          bright_d = brightness;
`endif
        end
      end
      BLANK: begin
        seg_d = SEG_W'(SEG_BLANK);
        an_d  = '0;
        if (!disp_enable) begin
          state_d = IDLE;
        end else begin
          cnt_clear = 1'b0;
          fd_d      = frame_last;
          if (drive_start) begin
            state_d = DRIVE;
            an_d    = NUM_DIGITS'(1) << digit_idx;
            seg_d   = snap_q[digit_idx];
          end
        end
      end
      DRIVE: begin
        if (!disp_enable) begin
          state_d = IDLE;
          seg_d   = SEG_W'(SEG_BLANK);
          an_d    = '0;
        end else begin
          cnt_clear = 1'b0;
          fd_d      = frame_last;
          if (slot_end) begin
            state_d = BLANK;
            seg_d   = SEG_W'(SEG_BLANK);
            an_d    = '0;
            // Snapshot only at the frame boundary so a frame never tears.
            if (frame_end) begin
              snap_d   = digit_segs_in;
`ifdef DIM_PWM_EN
              bright_d = brightness;
`endif
            end
          end else begin
`ifdef DIM_PWM_EN
            seg_d = (off_next <= bright_q) ? snap_q[digit_idx] : SEG_W'(SEG_BLANK);
`else
            seg_d = seg_q;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        seg_d   = SEG_W'(SEG_BLANK);
        an_d    = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst_b) begin
    if (rst_b) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      seg_q    <= '0;
      an_q     <= '0;
      fd_q     <= 1'b0;
`ifdef DIM_PWM_EN
      bright_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
`ifdef DIM_PWM_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with CLK_DIV=8, BLANK_CYCLES=2,
// NUM_DIGITS=6. Cycle k counts negedges after the enabling edge; the
// expected outputs for cycle k follow directly from the slot layout.
module tb_seg_display_scan;

  logic             sys_clk;
  logic             rst_b;
  logic [5:0][6:0]  digit_segs_in;
  logic             disp_enable;
  logic [6:0]       seg_out;
  logic [5:0]       an_out;
  logic             frame_done;
`ifdef DIM_PWM_EN
  logic [3:0]       brightness;
`endif

  int checks = 0;
  int passed = 0;

  seg_display_scan #(
    .NUM_DIGITS  (6),
    .SEG_W       (7),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_b        (rst_b),
    .digit_segs_in(digit_segs_in),
    .disp_enable  (disp_enable),
`ifdef DIM_PWM_EN
    .brightness   (brightness),
`endif
    .seg_out      (seg_out),
    .an_out       (an_out),
    .frame_done   (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // {seg_out, an_out, frame_done} expected k cycles after the enabling edge.
  function automatic logic [13:0] expect_at(input int k, input logic [5:0][6:0] d,
                                            input int bright);
    int slot;
    int dig;
    logic [6:0] s;
    logic [5:0] a;
    logic f;
    slot = k % 8;
    dig  = (k / 8) % 6;
    a = (slot >= 2) ? 6'(1 << dig) : 6'd0;
    s = (slot >= 2 && ((slot - 2) % 16) <= bright) ? d[dig] : 7'd0;
    f = (dig == 5) && (slot == 7);
    return {s, a, f};
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {seg_out, an_out, frame_done};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed seg/an/fd=%h expected %h", tag, obs, exp);
  endtask

  task automatic scan(input string tag, input int k0, input int n,
                      input logic [5:0][6:0] d, input int bright);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      check($sformatf("%s k=%0d", tag, k0 + i), expect_at(k0 + i, d, bright));
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      check($sformatf("%s cyc=%0d", tag, i), 14'h0);
    end
  endtask

  logic [5:0][6:0] d1, d2, d3;

  initial begin
    for (int i = 0; i < 6; i++) d1[i] = 7'(i + 1);
    d2 = d1;
    d2[0] = 7'h7F;
    d3 = d2;
    d3[1] = 7'h55;

    rst_b         = 1'b1;
    disp_enable   = 1'b0;
    digit_segs_in = d1;
`ifdef DIM_PWM_EN
    brightness    = 4'd15;
`endif
    #1;
    check("reset_async", 14'h0);
    @(negedge sys_clk);
    rst_b = 1'b0;
    idle_check("idle", 50);

    // Scan order over one frame, then tear-free snapshot across the wrap.
    disp_enable = 1'b1;
    scan("frame1", 0, 20, d1, 15);
    digit_segs_in[0] = 7'h7F;       // digit 2 is driving now
    scan("frame1", 20, 28, d1, 15);
    scan("frame2", 48, 48, d2, 15);

    // Disable during digit 3 drive.
    scan("frame3", 96, 28, d2, 15);
    disp_enable = 1'b0;
    idle_check("disabled", 60);

    // Re-enable with new data: fresh snapshot, restart at digit 0.
    digit_segs_in[1] = 7'h55;
    disp_enable = 1'b1;
    scan("reenable", 0, 13, d3, 15);

    // Async reset between edges while digit 1 is driving.
    #2;
    rst_b = 1'b1;
    #1;
    check("rst_mid_drive", 14'h0);
    disp_enable = 1'b0;
    @(negedge sys_clk);
    rst_b = 1'b0;
    idle_check("post_reset", 10);
    disp_enable = 1'b1;
    scan("after_reset", 0, 20, d3, 15);

`ifdef DIM_PWM_EN
    disp_enable = 1'b0;
    idle_check("pwm_off", 1);
    brightness  = 4'd3;
    disp_enable = 1'b1;
    scan("pwm3", 0, 16, d3, 3);
    disp_enable = 1'b0;
    idle_check("pwm_off", 1);
    brightness  = 4'd15;
    disp_enable = 1'b1;
    scan("pwm15", 0, 16, d3, 15);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
